// File: rtl/trap_sequencer.sv
`timescale 1ns/1ps
// Machine-mode trap sequencer: drains the pipeline for interrupts, saves trap CSRs,
// redirects fetch to mtvec, and sequences the MRET return path.
module trap_sequencer #(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_interrupt_req,
  input  logic [XLEN-1:0] i_interrupt_cause,
  input  logic            i_exc_valid,
  input  logic [XLEN-1:0] i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_retire_valid,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_mstatus_mie,
  input  logic            i_mstatus_mpie,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_csr_we,
  output logic [XLEN-1:0] o_mepc_wdata,
  output logic [XLEN-1:0] o_mcause_wdata,
  output logic [XLEN-1:0] o_mtval_wdata,
  output logic            o_mie_wdata,
  output logic            o_mpie_wdata,
  output logic            o_busy
);

  localparam int CNT_W = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    REDIRECT,
    MRET_RET
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  // Last values written to mepc/mcause/mtval, so MRET can rewrite them unchanged.
  logic [XLEN-1:0] mepc_wr_q, mepc_wr_d;
  logic [XLEN-1:0] mcause_wr_q, mcause_wr_d;
  logic [XLEN-1:0] mtval_wr_q, mtval_wr_d;

  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_offset;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] epc_aligned;

  assign vec_base    = i_mtvec & ALIGN_MASK;
  assign vec_offset  = {cause_q[XLEN-3:0], 2'b00};
  assign trap_target = ((i_mtvec[1:0] == 2'b01) && cause_q[XLEN-1]) ? (vec_base + vec_offset)
                                                                     : vec_base;
  assign epc_aligned = epc_q & ALIGN_MASK;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    mepc_wr_d   = mepc_wr_q;
    mcause_wr_d = mcause_wr_q;
    mtval_wr_d  = mtval_wr_q;

    case (state_q)
      IDLE: begin
        if (i_exc_valid) begin
          cause_d = i_exc_cause;
          epc_d   = i_exc_pc;
          tval_d  = i_exc_tval;
          state_d = SAVE;
        end else if (i_mret) begin
          state_d = MRET_RET;
        end else if (i_interrupt_req) begin
          cnt_d   = '0;
          cause_d = i_interrupt_cause;
          state_d = DRAIN;
        end
      end

      // An exception from the retiring instruction wins over the waiting interrupt,
      // which simply stays pending at the dispatcher and is picked up again from IDLE.
      DRAIN: begin
        if (i_exc_valid) begin
          cause_d = i_exc_cause;
          epc_d   = i_exc_pc;
          tval_d  = i_exc_tval;
          state_d = SAVE;
        end else if (!i_interrupt_req) begin
          state_d = IDLE;
        end else if (!i_retire_valid || (cnt_q == CNT_MAX)) begin
          epc_d   = i_next_pc;
          tval_d  = '0;
          state_d = SAVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SAVE: begin
        mepc_wr_d   = epc_aligned;
        mcause_wr_d = cause_q;
        mtval_wr_d  = tval_q;
        state_d     = REDIRECT;
      end

      REDIRECT: state_d = IDLE;

      MRET_RET: begin
        mepc_wr_d = i_mepc;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      tval_q      <= '0;
      mepc_wr_q   <= '0;
      mcause_wr_q <= '0;
      mtval_wr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      tval_q      <= tval_d;
      mepc_wr_q   <= mepc_wr_d;
      mcause_wr_q <= mcause_wr_d;
      mtval_wr_q  <= mtval_wr_d;
    end
  end

  // Output decode; only the IDLE stall/flush look at live inputs so the pipeline
  // is frozen in the same cycle the exception or MRET is reported.
  always_comb begin
    o_busy           = (state_q != IDLE);
    o_stall          = 1'b0;
    o_flush          = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_csr_we         = 1'b0;
    o_mepc_wdata     = mepc_wr_q;
    o_mcause_wdata   = mcause_wr_q;
    o_mtval_wdata    = mtval_wr_q;
    o_mie_wdata      = 1'b0;
    o_mpie_wdata     = 1'b0;

    case (state_q)
      IDLE: begin
        o_stall = i_exc_valid;
        o_flush = i_exc_valid | i_mret;
      end

      DRAIN: o_stall = 1'b1;

      SAVE: begin
        o_stall        = 1'b1;
        o_flush        = 1'b1;
        o_csr_we       = 1'b1;
        o_mepc_wdata   = epc_aligned;
        o_mcause_wdata = cause_q;
        o_mtval_wdata  = tval_q;
        o_mpie_wdata   = i_mstatus_mie;
        o_mie_wdata    = 1'b0;
      end

      REDIRECT: begin
        o_stall          = 1'b1;
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = trap_target;
      end

      MRET_RET: begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = i_mepc;
        o_csr_we         = 1'b1;
        o_mepc_wdata     = i_mepc;
        o_mie_wdata      = i_mstatus_mpie;
        o_mpie_wdata     = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter: XLEN, default 32; datapath width of PC, cause, tval and mtvec signals.
REQ-002 Parameter: DRAIN_MAX, default 15; maximum cycles spent waiting for a retire boundary before an interrupt is taken.
REQ-003 Ports: i_clk  in  1  clock; the single clock; all state updates on rising edge.
REQ-004 Ports: i_rst_n  in  1  reset; synchronous, active-low.
REQ-005 Ports: i_interrupt_req  in  1  pending enabled interrupt, from the interrupt dispatch block.
REQ-006 Ports: i_interrupt_cause  in  XLEN  mcause value for the interrupt; bit XLEN-1 is set.
REQ-007 Ports: i_exc_valid  in  1  synchronous exception reported by the retiring instruction.
REQ-008 Ports: i_exc_cause  in  XLEN  mcause value for the exception; bit XLEN-1 is clear.
REQ-009 Ports: i_exc_pc  in  XLEN  PC of the faulting instruction.
REQ-010 Ports: i_exc_tval  in  XLEN  mtval value for the exception.
REQ-011 Ports: i_retire_valid  in  1  an instruction retires this cycle.
REQ-012 Ports: i_next_pc  in  XLEN  PC of the next unretired instruction.
REQ-013 Ports: i_mret  in  1  the retiring instruction is MRET.
REQ-014 Ports: i_mtvec, i_mepc  in  XLEN each  current CSR values.
REQ-015 Ports: i_mstatus_mie, i_mstatus_mpie  in  1 each  current mstatus bits.
REQ-016 Ports: o_stall  out  1  freeze fetch/issue.
REQ-017 Ports: o_flush  out  1  kill all in-flight instructions.
REQ-018 Ports: o_redirect_valid  out  1  one-cycle PC load strobe.
REQ-019 Ports: o_redirect_pc  out  XLEN  target PC for the redirect.
REQ-020 Ports: o_csr_we  out  1  one-cycle strobe writing mepc, mcause, mtval and mstatus.MIE/MPIE.
REQ-021 Ports: o_mepc_wdata, o_mcause_wdata, o_mtval_wdata  out  XLEN each  CSR write data.
REQ-022 Ports: o_mie_wdata, o_mpie_wdata  out  1 each  mstatus write data.
REQ-023 Ports: o_busy  out  1  FSM not in IDLE.

Function
REQ-024 FSM states SHALL be IDLE, DRAIN, SAVE, REDIRECT and MRET_RET.
REQ-025 In IDLE, event priority SHALL be i_exc_valid, then i_mret, then i_interrupt_req.
REQ-026 IDLE with i_exc_valid=1: latch cause=i_exc_cause, epc=i_exc_pc, tval=i_exc_tval; go to SAVE; o_stall and o_flush assert the same cycle (combinational).
REQ-027 IDLE with i_mret=1 and no exception: go to MRET_RET; o_flush asserts the same cycle.
REQ-028 IDLE with i_interrupt_req=1 only: go to DRAIN; clear drain counter; latch cause=i_interrupt_cause; o_stall asserts from the next cycle.
REQ-029 In DRAIN, o_stall=1 and the counter increments each cycle.
REQ-030 DRAIN exits to SAVE on i_retire_valid=0 or counter==DRAIN_MAX, with epc=i_next_pc and tval=0.
REQ-031 In DRAIN, i_exc_valid=1 SHALL preempt the interrupt: relatch exception fields, go to SAVE; the interrupt stays pending and is re-evaluated later.
REQ-032 DRAIN returns to IDLE with no CSR write if i_interrupt_req deasserts before exit.
REQ-033 SAVE lasts exactly one cycle: o_csr_we=1, o_stall=1, o_flush=1.
REQ-034 SAVE write data: o_mepc_wdata=epc with bits[1:0] forced 0; o_mcause_wdata=cause; o_mtval_wdata=tval; o_mpie_wdata=i_mstatus_mie; o_mie_wdata=0.
REQ-035 From SAVE, go to REDIRECT.
REQ-036 REDIRECT lasts one cycle: o_redirect_valid=1, o_stall=1, o_flush=1; then go to IDLE.
REQ-037 Redirect target: if i_mtvec[1:0]==01 and cause[XLEN-1]==1, target={i_mtvec[XLEN-1:2],2'b00}+4*cause[XLEN-2:0], truncated to XLEN; otherwise {i_mtvec[XLEN-1:2],2'b00}.
REQ-038 MRET_RET lasts one cycle: o_csr_we=1, o_mie_wdata=i_mstatus_mpie, o_mpie_wdata=1, o_redirect_valid=1, o_redirect_pc=i_mepc, o_flush=1; then go to IDLE.
REQ-039 In MRET_RET, mepc/mcause/mtval write data SHALL equal the current values, held unchanged.
REQ-040 Inputs i_exc_valid, i_mret and i_interrupt_req SHALL be ignored in SAVE, REDIRECT and MRET_RET.
REQ-041 An interrupt pending with MRET SHALL be taken from IDLE on the cycle after MRET_RET.
REQ-042 o_busy=1 in every state except IDLE.
REQ-043 In IDLE with no event, o_stall, o_flush, o_redirect_valid and o_csr_we SHALL all be 0.

Reset
REQ-044 On i_rst_n=0 at a rising edge: state=IDLE, drain counter=0, latched cause/epc/tval=0.
REQ-045 On reset, all strobes and o_busy SHALL be 0.
REQ-046 On reset, o_redirect_pc and all CSR write data SHALL be 0.
REQ-047 Reset asserted in any state SHALL abort the sequence with no further CSR write or redirect.

Verification
REQ-048 Exception: i_exc_valid=1, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x200, MIE=1 -> next cycle o_csr_we with mepc=0x100, mcause=2, mtval=0xDEAD, MPIE=1, MIE=0; following cycle redirect to 0x200.
REQ-049 Vectored timer interrupt: mtvec=0x201, cause=0x80000007, retire low, next_pc=0x44 -> DRAIN 1 cycle, SAVE with mepc=0x44, redirect to 0x21C.
REQ-050 Drain timeout: i_retire_valid held 1, DRAIN_MAX=15 -> SAVE entered exactly 16 cycles after leaving IDLE.
REQ-051 Exception in DRAIN: exception cause=5 arrives in cycle 2 of DRAIN -> mcause=5, tval=exception tval; interrupt taken after the return to IDLE.
REQ-052 MRET with interrupt pending: mepc=0x300, MPIE=1 -> redirect to 0x300, MIE=1; next cycle enter DRAIN.
REQ-053 Reset mid-SAVE: i_rst_n=0 during SAVE -> no REDIRECT; all outputs 0 the next cycle.
